// File: rtl/network_pkg.sv
// Ethernet constants and TX framer state encoding, shared by the TX and RX datapaths.
package network_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [3:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_SFD,
    TX_DATA,
    TX_PAD,
    TX_FCS,
    TX_ERR,
    TX_DRAIN,
    TX_IFG
  } tx_state_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update for one byte (no init, no final inversion).
module crc32_byte
  import network_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/eth_mac_tx_framer.sv
// GMII TX framer: preamble/SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
// All GMII outputs registered; a byte accepted in cycle t is on o_gmii_txd in cycle t+1.
module eth_mac_tx_framer
  import network_pkg::*;
#(
  parameter int IFG_BYTES    = 12,
  parameter int MIN_PAYLOAD  = 60,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] o_gmii_txd,
  output logic       o_gmii_txen,
  output logic       o_gmii_txer,
  output logic       o_frame_done
);

  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES);

  tx_state_t   state_q;
  logic [10:0] cnt_q, cnt_inc_d;
  logic [31:0] crc_q, crc_d, fcs_d;
  logic [7:0]  crc_byte_d, fcs_byte_d, txd_q;
  logic        txen_q, txer_q, done_q;

  assign s_axis_tready = (state_q == TX_DATA) || (state_q == TX_DRAIN);
  assign cnt_inc_d     = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign crc_byte_d    = (state_q == TX_DATA) ? s_axis_tdata : 8'h00;
  assign fcs_d         = ~crc_q;
  assign fcs_byte_d    = fcs_d[{cnt_q[1:0], 3'b000} +: 8];

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_byte_d),
    .crc_o  (crc_d)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      crc_q   <= CRC32_INIT;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      txd_q  <= 8'h00;
      txen_q <= 1'b0;
      txer_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        // The first preamble byte is issued on the IDLE exit so txen rises one cycle after tvalid.
        TX_IDLE: if (s_axis_tvalid) begin
          state_q <= TX_PREAMBLE;
          txd_q   <= ETH_PREAMBLE;
          txen_q  <= 1'b1;
          cnt_q   <= 11'd1;
        end
        TX_PREAMBLE: begin
          txd_q  <= ETH_PREAMBLE;
          txen_q <= 1'b1;
          cnt_q  <= cnt_q + 11'd1;
          if (cnt_q == PRE_LAST) state_q <= TX_SFD;
        end
        TX_SFD: begin
          txd_q   <= ETH_SFD;
          txen_q  <= 1'b1;
          crc_q   <= CRC32_INIT;
          cnt_q   <= '0;
          state_q <= TX_DATA;
        end
        TX_DATA: begin
          txen_q <= 1'b1;
          if (s_axis_tvalid) begin
            txd_q <= s_axis_tdata;
            crc_q <= crc_d;
            cnt_q <= cnt_inc_d;
            if (s_axis_tlast) begin
              if (cnt_inc_d < MIN_CNT) begin
                state_q <= TX_PAD;
              end else begin
                state_q <= TX_FCS;
                cnt_q   <= '0;
              end
            end
          end else begin
            txer_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= TX_ERR;
          end
        end
        TX_PAD: begin
          txen_q <= 1'b1;
          crc_q  <= crc_d;
          if (cnt_inc_d == MIN_CNT) begin
            state_q <= TX_FCS;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        TX_FCS: begin
          txd_q  <= fcs_byte_d;
          txen_q <= 1'b1;
          cnt_q  <= cnt_q + 11'd1;
          if (cnt_q[1:0] == 2'd3) begin
            done_q  <= 1'b1;
            state_q <= TX_IFG;
            cnt_q   <= '0;
          end
        end
        // Underflow can only happen before tlast is accepted, so the rest of the frame is always drained.
        TX_ERR: state_q <= TX_DRAIN;
        TX_DRAIN: if (s_axis_tvalid && s_axis_tlast) begin
          state_q <= TX_IFG;
          cnt_q   <= '0;
        end
        // IFG_BYTES+1 gap cycles here, so IDLE's decision cycle lands on the last idle wire byte.
        TX_IFG: begin
          if (cnt_q == IFG_LAST) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign o_gmii_txd   = txd_q;
  assign o_gmii_txen  = txen_q;
  assign o_gmii_txer  = txer_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// Directed bench for eth_mac_tx_framer: captures each txen burst and checks framing, pad, FCS and gaps.
module tb_eth_mac_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0, tlast = 1'b0;
  logic       tready, txen, txer, done;
  logic [7:0] txd;

  int n_pass = 0, n_total = 0;

  always #4 clk = ~clk;

  eth_mac_tx_framer dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .o_gmii_txd    (txd),
    .o_gmii_txen   (txen),
    .o_gmii_txer   (txer),
    .o_frame_done  (done)
  );

  // Wire monitor: one captured frame per contiguous txen burst.
  logic [7:0] cur[$], got[$];
  int in_fr = 0, nframes = 0, gap_cnt = 0, gap_rdy = 0, last_gap = 0, last_gap_rdy = 0;
  int cur_done = 0, cur_er = 0, got_done = 0, got_er = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_fr = 0; gap_cnt = 0; gap_rdy = 0;
    end else if (txen) begin
      if (in_fr == 0) begin
        cur.delete(); last_gap = gap_cnt; last_gap_rdy = gap_rdy;
        cur_done = 0; cur_er = 0; in_fr = 1;
      end
      cur.push_back(txd);
      if (txer && cur_er == 0) cur_er = cur.size();
      if (done) cur_done = cur.size();
    end else begin
      if (in_fr != 0) begin
        got = cur; got_done = cur_done; got_er = cur_er;
        nframes++; in_fr = 0; gap_cnt = 0; gap_rdy = 0;
      end
      gap_cnt++;
      if (tready) gap_rdy++;
    end
  end

  function automatic logic [31:0] crc_step(logic [31:0] c, logic [7:0] b);
    logic [31:0] r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic bit pre_ok();
    if (got.size() < 8) return 1'b0;
    for (int i = 0; i < 7; i++) if (got[i] !== 8'h55) return 1'b0;
    return got[7] === 8'hD5;
  endfunction

  function automatic logic [31:0] resid();
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 8; i < got.size(); i++) c = crc_step(c, got[i]);
    return c;
  endfunction

  function automatic bit body_ok(int n, int base);
    int m = (n < 60) ? 60 : n;
    if (got.size() != 8 + m + 4) return 1'b0;
    for (int i = 0; i < m; i++) begin
      logic [7:0] e = (i < n) ? 8'(base + i) : 8'h00;
      if (got[8 + i] !== e) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_fcs(int n, int base);
    logic [31:0] c = 32'hFFFFFFFF;
    int m = (n < 60) ? 60 : n;
    for (int i = 0; i < m; i++) c = crc_step(c, (i < n) ? 8'(base + i) : 8'h00);
    return ~c;
  endfunction

  function automatic logic [31:0] got_fcs();
    int s = got.size();
    return {got[s-1], got[s-2], got[s-3], got[s-4]};
  endfunction

  // Drives one frame; called at a negedge. uf_at >= 0 drops tvalid for one cycle before that byte.
  task automatic send(input int n, input int base, input int uf_at);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (i == uf_at) begin
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
      end
      tvalid = 1'b1; tdata = 8'(base + i); tlast = (i == n - 1);
      while (!tready && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) begin
        n_total++;
        $display("FAIL send_timeout: byte %0d never accepted after %0d cycles", i, t);
        tvalid = 1'b0; tlast = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_frame(input int k);
    int t = 0;
    while (nframes < k && t < 20000) begin @(negedge clk); #1; t++; end
    n_total++;
    if (nframes < k) $display("FAIL frame_wait: frames seen %0d, required %0d", nframes, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    n_total++; if (txen !== 1'b0) $display("FAIL rst_txen: got %b want 0", txen); else n_pass++;
    n_total++; if (txer !== 1'b0) $display("FAIL rst_txer: got %b want 0", txer); else n_pass++;
    n_total++; if (txd !== 8'h00) $display("FAIL rst_txd: got %h want 00", txd); else n_pass++;
    n_total++; if (tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", tready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_total++; if (txen !== 1'b0) $display("FAIL idle_txen: got %b want 0", txen); else n_pass++;
  endtask

  task automatic test_frame_64();
    int k = nframes;
    tvalid = 1'b1; tdata = 8'h00; tlast = 1'b0;
    @(negedge clk);
    n_total++;
    if (txen !== 1'b1 || txd !== 8'h55) $display("FAIL head_latency: txen=%b txd=%h want 1/55", txen, txd);
    else n_pass++;
    send(64, 0, -1);
    wait_frame(k + 1);
    n_total++; if (got.size() != 76) $display("FAIL f64_len: got %0d want 76", got.size()); else n_pass++;
    n_total++; if (!pre_ok()) $display("FAIL f64_preamble: got %0d want 1", pre_ok()); else n_pass++;
    n_total++; if (!body_ok(64, 0)) $display("FAIL f64_payload: got %0d want 1", body_ok(64, 0)); else n_pass++;
    n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL f64_residue: got %h want debb20e3", resid()); else n_pass++;
    n_total++; if (got_fcs() !== exp_fcs(64, 0)) $display("FAIL f64_fcs: got %h want %h", got_fcs(), exp_fcs(64, 0)); else n_pass++;
    n_total++; if (got_done != 76) $display("FAIL f64_done: got %0d want 76", got_done); else n_pass++;
    n_total++; if (got_er != 0) $display("FAIL f64_txer: got %0d want 0", got_er); else n_pass++;
  endtask

  task automatic test_pad_14();
    int k = nframes;
    send(14, 8'hA0, -1);
    wait_frame(k + 1);
    n_total++; if (got.size() != 72) $display("FAIL pad_len: got %0d want 72", got.size()); else n_pass++;
    n_total++; if (!body_ok(14, 8'hA0)) $display("FAIL pad_bytes: got %0d want 1", body_ok(14, 8'hA0)); else n_pass++;
    n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL pad_residue: got %h want debb20e3", resid()); else n_pass++;
    n_total++; if (got_fcs() !== exp_fcs(14, 8'hA0)) $display("FAIL pad_fcs: got %h want %h", got_fcs(), exp_fcs(14, 8'hA0)); else n_pass++;
    n_total++; if (got_done != 72) $display("FAIL pad_done: got %0d want 72", got_done); else n_pass++;
  endtask

  task automatic test_boundary();
    int k = nframes;
    send(1, 8'h7E, -1);
    wait_frame(k + 1);
    n_total++; if (!body_ok(1, 8'h7E)) $display("FAIL n1_bytes: got %0d want 1", body_ok(1, 8'h7E)); else n_pass++;
    n_total++; if (got_fcs() !== exp_fcs(1, 8'h7E)) $display("FAIL n1_fcs: got %h want %h", got_fcs(), exp_fcs(1, 8'h7E)); else n_pass++;
    send(60, 8'h11, -1);
    wait_frame(k + 2);
    n_total++; if (got.size() != 72) $display("FAIL n60_len: got %0d want 72", got.size()); else n_pass++;
    n_total++; if (got_fcs() !== exp_fcs(60, 8'h11)) $display("FAIL n60_fcs: got %h want %h", got_fcs(), exp_fcs(60, 8'h11)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k = nframes;
    fork
      begin send(100, 0, -1); send(100, 8'h10, -1); end
    join_none
    wait_frame(k + 1);
    n_total++; if (got.size() != 112) $display("FAIL b2b_len1: got %0d want 112", got.size()); else n_pass++;
    n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL b2b_residue1: got %h want debb20e3", resid()); else n_pass++;
    wait_frame(k + 2);
    n_total++; if (last_gap != 13) $display("FAIL b2b_gap: got %0d want 13", last_gap); else n_pass++;
    n_total++; if (last_gap_rdy != 0) $display("FAIL b2b_gap_tready: got %0d want 0", last_gap_rdy); else n_pass++;
    n_total++; if (!body_ok(100, 8'h10)) $display("FAIL b2b_body2: got %0d want 1", body_ok(100, 8'h10)); else n_pass++;
    n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL b2b_residue2: got %h want debb20e3", resid()); else n_pass++;
    wait fork;
  endtask

  task automatic test_underflow();
    int k = nframes;
    send(100, 0, 21);
    wait_frame(k + 1);
    n_total++; if (got.size() != 30) $display("FAIL uf_len: got %0d want 30", got.size()); else n_pass++;
    n_total++; if (got[29] !== 8'h00) $display("FAIL uf_txd: got %h want 00", got[29]); else n_pass++;
    n_total++; if (got_er != 30) $display("FAIL uf_txer_pos: got %0d want 30", got_er); else n_pass++;
    n_total++; if (got_done != 30) $display("FAIL uf_done_pos: got %0d want 30", got_done); else n_pass++;
    send(20, 8'h40, -1);
    wait_frame(k + 2);
    n_total++; if (last_gap_rdy != 79) $display("FAIL uf_drain_tready: got %0d want 79", last_gap_rdy); else n_pass++;
    n_total++; if (last_gap != 93) $display("FAIL uf_gap: got %0d want 93", last_gap); else n_pass++;
    n_total++; if (!body_ok(20, 8'h40)) $display("FAIL uf_next_body: got %0d want 1", body_ok(20, 8'h40)); else n_pass++;
    n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL uf_next_residue: got %h want debb20e3", resid()); else n_pass++;
    n_total++; if (got_er != 0) $display("FAIL uf_next_txer: got %0d want 0", got_er); else n_pass++;
  endtask

  task automatic test_reset_mid_fcs();
    int k, t = 0;
    send(60, 8'h30, -1);
    while (!(in_fr != 0 && cur.size() == 70) && t < 200) begin @(negedge clk); #1; t++; end
    n_total++;
    if (txen !== 1'b1) $display("FAIL mid_fcs_reach: txen %b want 1 at FCS byte 2", txen); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({txen, txer, done, tready, txd} !== 12'h000)
      $display("FAIL mid_rst_outputs: got txen=%b txer=%b done=%b tready=%b txd=%h want all 0", txen, txer, done, tready, txd);
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    k = nframes;
    send(30, 8'h80, -1);
    wait_frame(k + 1);
    n_total++; if (!pre_ok()) $display("FAIL post_rst_preamble: got %0d want 1", pre_ok()); else n_pass++;
    n_total++; if (!body_ok(30, 8'h80)) $display("FAIL post_rst_body: got %0d want 1", body_ok(30, 8'h80)); else n_pass++;
    n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL post_rst_residue: got %h want debb20e3", resid()); else n_pass++;
  endtask

  task automatic test_random_len();
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 300);
      int base = $urandom_range(0, 255);
      int k = nframes;
      int m = (n < 60) ? 60 : n;
      send(n, base, -1);
      wait_frame(k + 1);
      n_total++; if (got.size() != 12 + m) $display("FAIL rnd_len: n=%0d got %0d want %0d", n, got.size(), 12 + m); else n_pass++;
      n_total++; if (resid() !== 32'hDEBB20E3) $display("FAIL rnd_residue: n=%0d got %h want debb20e3", n, resid()); else n_pass++;
      n_total++; if (!body_ok(n, base)) $display("FAIL rnd_body: n=%0d got %0d want 1", n, body_ok(n, base)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_frame_64();
    test_pad_14();
    test_boundary();
    test_back_to_back();
    test_underflow();
    test_reset_mid_fcs();
    test_random_len();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eth_mac_tx_framer.md
Name: eth_mac_tx_framer

Overview:
Transmit-side MAC framer. It converts an AXI-stream byte payload (dest MAC through end of payload) into a complete GMII-level Ethernet frame:
- 7x preamble byte plus SFD
- payload, zero-padded to the minimum frame size
- CRC-32 FCS
- enforced inter-frame gap

It sits between the TX FIFO and the RGMII TX DDR output stage in ethernet_mac_project_top. It is the counterpart of the RX deframer path.

Parameters:
- IFG_BYTES, 12, minimum idle cycles (txen=0) between frames
- MIN_PAYLOAD, 60, minimum bytes before FCS; shorter payloads are zero-padded
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD

Ports:
- i_clk  in  1  byte clock (125 MHz at 1G)
- i_reset_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  payload byte valid
- s_axis_tlast  in  1  last payload byte of frame
- s_axis_tready  out  1  framer accepts byte this cycle
- o_gmii_txd  out  8  transmit byte to RGMII stage
- o_gmii_txen  out  1  transmit enable
- o_gmii_txer  out  1  transmit error (underflow)
- o_frame_done  out  1  one-cycle pulse when the last FCS byte or error byte is driven

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - o_gmii_txd=0x00, o_gmii_txen=0, o_gmii_txer=0
  - s_axis_tready=0, o_frame_done=0
  - byte counter=0, CRC=0xFFFFFFFF
- Reset mid-frame: the outputs above take effect immediately (async). No partial FCS is emitted.
- All GMII outputs are registered. A byte accepted in cycle t appears on o_gmii_txd in cycle t+1.
- FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ERR, DRAIN, IFG.
- IDLE:
  - tready=0, txen=0.
  - If tvalid=1, go to PREAMBLE. txen rises on the next cycle.
  - Head-of-frame latency: 1 cycle.
- PREAMBLE: drive 0x55 for PREAMBLE_LEN cycles (counter), then go to SFD.
- SFD: drive 0xD5; reset CRC to 0xFFFFFFFF and byte count to 0; go to DATA.
- DATA:
  - tready=1 (combinational from state).
  - On tvalid&tready: output the byte, update CRC, increment count (11-bit, saturating at 2047).
  - On tlast accept: if count+1 < MIN_PAYLOAD go to PAD, else go to FCS.
  - If tvalid=0 in DATA (underflow): go to ERR.
- PAD: drive 0x00 with CRC update until count==MIN_PAYLOAD, then go to FCS.
- FCS:
  - Drive ~CRC for 4 cycles, LSB byte first (bits [7:0], then [15:8], [23:16], [31:24]).
  - o_frame_done pulses with the 4th byte; go to IFG.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise update, final inversion. It covers payload and pad only, not preamble/SFD.
- ERR:
  - One cycle with txen=1, txer=1, txd=0x00; o_frame_done pulses.
  - If the underflowed frame's tlast has not yet been seen, go to DRAIN, else go to IFG.
- DRAIN: txen=0; tready=1; discard bytes until tlast is accepted; then go to IFG.
- IFG: txen=0, tready=0 for IFG_BYTES cycles, then go to IDLE. A waiting tvalid is not accepted early.
- Wire occupancy of a good frame with N payload bytes: 8 + max(N, MIN_PAYLOAD) + 4 cycles of txen=1. These are contiguous, with no bubbles.
- Boundary cases:
  - tlast on the first DATA byte (N=1): pads 59 bytes.
  - N=60 exactly: no PAD state.
  - Back-to-back frames: gap is exactly IFG_BYTES+1 cycles from the last FCS byte to the next first preamble byte (IFG count plus the IDLE cycle).

Decomposition:
- network_pkg, shared with RX:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT, CRC32_RESIDUE=32'hDEBB20E3
  - the tx_state_t enum
- Sub-module crc32_byte: combinational next-CRC for one byte. Reused by the RX FCS checker.

Test Plan:
- 64-byte payload 0x00..0x3F: txen high for 76 contiguous cycles; bytes 0-6=0x55, byte 7=0xD5; payload follows; running CRC over payload+FCS = 0xDEBB20E3; o_frame_done on cycle 76.
- 14-byte payload: 46 pad bytes of 0x00 follow it; txen high for 72 cycles; FCS is valid over all 60 bytes.
- Two back-to-back 100-byte frames with tvalid held high: exactly 13 txen=0 cycles between frames; tready=0 throughout the gap.
- tvalid drops after payload byte 20:
  - next cycle txen=1, txer=1, txd=0x00, o_frame_done=1;
  - the rest of the frame up to tlast is discarded (tready=1, txen=0);
  - the next frame is transmitted cleanly.
- i_reset_n pulsed low during an FCS byte: all outputs 0 in the same cycle; the next frame after reset starts with a full preamble and a correct CRC.
- Randomised N in 1..1500 for 100 frames through the RGMII BFM reader: every frame has a valid residue and length max(N,60)+4 after SFD.
